// File: rtl/logic_result_stage.sv
// logic_result_stage: buffers logical-unit results with derived status flags
// in a small FIFO and presents them over a valid/ready handshake.
// Optional macro LOGIC_RESULT_PARITY_EN adds a per-entry even-parity bit
// on output res_par.
module logic_result_stage #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   lu_result,
    input  logic [2:0]    lu_sel,
    input  logic          flush,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [15:0]   res_data,
    output logic [2:0]    res_sel,
    output logic          res_zero,
    output logic          res_neg,
    output logic          res_ovf,
`ifdef LOGIC_RESULT_PARITY_EN
    output logic          res_par,
`endif
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [2:0]  sel;
        logic [15:0] data;
        logic        zero;
        logic        neg;
        logic        ovf;
`ifdef LOGIC_RESULT_PARITY_EN
        logic        par;
`endif
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        new_e;
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          push;
    logic          pop;

    // Full/empty come from the occupancy counter only, so in_ready never
    // looks at res_ready: a full stage refuses a push even while popping.
    assign in_ready  = (cnt != CW'(DEPTH));
    assign res_valid = (cnt != '0);
    assign push      = in_valid && in_ready;
    assign pop       = res_valid && res_ready;
    assign count     = cnt;

    // Flags are derived once, at capture time, and travel with the entry.
    always_comb begin
        new_e      = '0;
        new_e.sel  = lu_sel;
        new_e.data = lu_result;
        new_e.zero = ~|lu_result;
        new_e.neg  = lu_result[15];
        new_e.ovf  = (lu_sel == 3'b111) && (lu_result == 16'h8000);
`ifdef LOGIC_RESULT_PARITY_EN
        new_e.par  = ^lu_result;
`endif
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= new_e;
    end

    // Pointers and occupancy; flush overrides any push/pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Head entry is masked to zero while empty so stale storage never leaks.
    always_comb begin
        head     = res_valid ? mem[rd_ptr] : '0;
        res_data = head.data;
        res_sel  = head.sel;
        res_zero = head.zero;
        res_neg  = head.neg;
        res_ovf  = head.ovf;
`ifdef LOGIC_RESULT_PARITY_EN
        res_par  = head.par;
`endif
    end

endmodule
